fetch_queue: RTL
================

# fetch_queue

Instruction queue between the fetch stage (program-counter register plus instruction memory) and the decode stage of the pipelined MIPS core. It buffers fetched PC/instruction pairs so fetch can keep running while decode stalls, and exposes its "full" condition as the fetch stall. A branch/jump redirect flushes all buffered entries in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width, equal to log2(DEPTH).

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- f_pc  input  32  PC of the instruction being fetched.
- f_instr  input  32  instruction word from instruction memory.
- f_valid  input  1  push request for the f_pc/f_instr pair.
- fd_stall  output  1  asserted when the queue is full; drives the PC register's stall input.
- flush  input  1  discards all entries; comes from the redirect logic.
- d_stall  input  1  decode cannot accept the head entry this cycle.
- d_pc  output  32  PC of the head entry; 0 when the queue is empty.
- d_instr  output  32  instruction of the head entry; 0 (nop) when the queue is empty.
- d_valid  output  1  queue is non-empty.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- ovf  output  1  sticky flag: a push was attempted while the queue was full.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {pc, instr}.
- Read pointer rd_ptr and write pointer wr_ptr are AW bits wide and wrap modulo DEPTH.
- Occupancy is kept in an explicit counter (AW+1 bits).
- A push occurs when f_valid is high and count < DEPTH and flush is low. The pair is written at wr_ptr, then wr_ptr increments.
- A pop occurs when d_valid is high and d_stall is low and flush is low. rd_ptr increments.
- Count update:
  - Push only: count + 1.
  - Pop only: count − 1.
  - Push and pop together: count is unchanged.
- Flush has priority over push and pop. It resets rd_ptr, wr_ptr and count to 0. Storage contents are don't-care. ovf is not cleared by flush.
- fd_stall = (count == DEPTH). It is computed from registered state only, with no combinational path from d_stall. A pop while full does not allow a same-cycle push.
- ovf sets on f_valid & fd_stall & !flush. It clears only on reset.
- The d_* outputs read combinationally from the entry at rd_ptr. When empty, d_pc and d_instr are forced to 0.

## Timing
- Reset (asynchronous) forces these values immediately:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - d_valid = 0, d_pc = 0, d_instr = 0.
  - fd_stall = 0, ovf = 0.
- Push-to-visible latency is one cycle: data pushed at edge N appears on d_* after edge N.
- Pop takes effect at the edge. The next entry appears on d_* after that edge.
- A full queue with a pop at edge N deasserts fd_stall after edge N. A push can then be accepted at edge N+1.
- When empty, a push and a pop cannot happen in the same cycle, because d_valid is low. Count goes from 0 to 1.
- Flush in the same cycle as f_valid: the incoming pair is dropped, and count = 0 after the edge.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers are back at 0 and order is preserved (FIFO).
- Reset asserted mid-operation clears state immediately and asynchronously. The first push after reset is accepted on the first rising edge where reset is low.

## Test plan
- Reset, then push 0x3000/0x24010001 with d_stall=1:
  - After one edge: d_valid=1, d_pc=0x3000, d_instr=0x24010001, count=1.
- Fill with d_stall=1, pushing PCs 0x3000, 0x3004, 0x3008, 0x300c:
  - count=4, fd_stall=1.
  - A further push of 0x3010 sets ovf=1 and leaves count=4 and the head at 0x3000.
- Full queue, then d_stall=0 with f_valid=1 for one cycle:
  - After the edge: count=3, head=0x3004, fd_stall=0.
  - The next edge pushes 0x3010, so count=4.
- Streaming: push and pop every cycle for 10 cycles, PCs 0x3000..0x3024:
  - count stays 1.
  - d_pc sequence lags the push sequence by exactly one cycle, across pointer wrap.
- Flush with count=3 and f_valid=1 in the same cycle:
  - After the edge: count=0, d_valid=0, d_instr=0. ovf keeps its prior value.
- Assert reset asynchronously between edges with count=2:
  - Outputs clear before the next edge: d_valid=0, count=0, fd_stall=0, ovf=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: a circular buffer of PC/instruction pairs.
// Full stalls fetch, and a redirect flush empties the queue in one cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   f_pc,
  input  logic [31:0]   f_instr,
  input  logic          f_valid,
  output logic          fd_stall,
  input  logic          flush,
  input  logic          d_stall,
  output logic [31:0]   d_pc,
  output logic [31:0]   d_instr,
  output logic          d_valid,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [31:0]   pcMem_q    [DEPTH];
  logic [31:0]   instrMem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fullQ, emptyQ, doPush, doPop;

  // Full and empty come only from registered state, so d_stall never reaches fd_stall.
  assign fullQ  = (count_q == FullCount);
  assign emptyQ = (count_q == '0);
  assign doPush = f_valid && !fullQ && !flush;
  assign doPop  = !emptyQ && !d_stall && !flush;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (f_valid && fullQ && !flush) begin
      ovf_d = 1'b1;
    end
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      if (doPush && !doPop) begin
        count_d = count_q + 1'b1;
      end else if (doPop && !doPush) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (doPush) begin
      pcMem_q[wrPtr_q]    <= f_pc;
      instrMem_q[wrPtr_q] <= f_instr;
    end
  end

  assign fd_stall = fullQ;
  assign d_valid  = !emptyQ;
  assign d_pc     = emptyQ ? 32'h0 : pcMem_q[rdPtr_q];
  assign d_instr  = emptyQ ? 32'h0 : instrMem_q[rdPtr_q];
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule
